// File: rtl/fetch_pc_ir.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_pc_ir
//  Description : Fetch stage sitting directly upstream of the instruction ROM.
//                Owns the program counter, drives the ROM word address and
//                captures the returned word into an instruction register that
//                is offered to decode through a valid/ready handshake.
//                Handles branch redirect, decode back-pressure and halting
//                once the PC runs past the loaded program.
//  Ports       : clk, rst        - clock, synchronous active-high reset
//                rom_addr        - ROM word address (pc[ADDR_W+1:2])
//                rom_data        - ROM read word, stable before rising edge
//                br_taken        - redirect request from execute
//                br_target       - redirect byte address (bits [1:0] ignored)
//                ir_ready        - decode accepts ir this cycle
//                ir_valid, ir    - instruction register and its valid flag
//                ir_pc           - byte address of the instruction in ir
//                pc              - current fetch byte address
//                halted          - high while in the HALT state
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_pc_ir #(
    parameter int          ADDR_W   = 6,
    parameter int          PROG_LEN = 12,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [31:0]       rom_data,
    input  logic              br_taken,
    input  logic [31:0]       br_target,
    input  logic              ir_ready,
    output logic              ir_valid,
    output logic [31:0]       ir,
    output logic [31:0]       ir_pc,
    output logic [31:0]       pc,
    output logic              halted
);

    localparam logic [0:0]  c_st_fetch = 1'b0;
    localparam logic [0:0]  c_st_halt  = 1'b1;
    localparam logic [29:0] c_prog_len = PROG_LEN[29:0];

    logic [0:0]  r_state;
    logic [31:0] r_pc;
    logic [31:0] r_ir;
    logic [31:0] r_ir_pc;
    logic        r_ir_valid;
    logic        r_halted;

    logic        w_hold;
    logic        w_end;
    logic [31:0] w_target;

    // A word is held only while decode refuses it.
    assign w_hold   = r_ir_valid & ~ir_ready;
    // The full word index is compared, so wrapped or far-away addresses halt
    // instead of aliasing onto a truncated ROM address.
    assign w_end    = (r_pc[31:2] >= c_prog_len);
    assign w_target = br_target & ~32'h0000_0003;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc       <= RESET_PC;
            r_ir       <= '0;
            r_ir_pc    <= '0;
            r_ir_valid <= 1'b0;
            r_state    <= c_st_fetch;
            r_halted   <= 1'b0;
        end else if (br_taken) begin
            // Redirect squashes whatever sits in ir, even mid-stall.
            r_pc       <= w_target;
            r_ir_valid <= 1'b0;
            r_state    <= c_st_fetch;
            r_halted   <= 1'b0;
        end else if (!w_hold) begin
            case (r_state)
                c_st_fetch: begin
                    if (w_end) begin
                        r_ir_valid <= 1'b0;
                        r_state    <= c_st_halt;
                        r_halted   <= 1'b1;
                    end else begin
                        r_ir       <= rom_data;
                        r_ir_pc    <= r_pc;
                        r_ir_valid <= 1'b1;
                        r_pc       <= r_pc + 32'd4;
                    end
                end
                default: begin
                    // HALT: everything frozen until redirect or reset.
                    r_ir_valid <= 1'b0;
                end
            endcase
        end
    end

    assign rom_addr = r_pc[ADDR_W+1:2];
    assign ir_valid = r_ir_valid;
    assign ir       = r_ir;
    assign ir_pc    = r_ir_pc;
    assign pc       = r_pc;
    assign halted   = r_halted;

endmodule
`default_nettype wire

// File: doc/fetch_pc_ir.md
Name: fetch_pc_ir

Overview:
- Fetch stage directly upstream of the instruction ROM.
- Owns the program counter and drives the ROM word address.
- Captures the returned instruction word into an instruction register with a valid/ready handshake toward decode.
- Handles branch redirect, decode back-pressure, and halting at the end of the loaded program.

Parameters:
ADDR_W, 6, ROM word-address width (ROM depth 2^ADDR_W words)
PROG_LEN, 12, number of valid program words; word index >= PROG_LEN is end-of-program
RESET_PC, 32'h0000_0000, byte address loaded into PC on reset (word aligned)

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
rom_addr  output  ADDR_W  word address to ROM = pc[ADDR_W+1:2], combinational from pc
rom_data  input  32  ROM read data; ROM samples rom_addr on falling edge, so the word is stable before the next rising edge
br_taken  input  1  redirect request from execute, sampled on rising edge
br_target  input  32  redirect byte address; bits [1:0] ignored (forced 0)
ir_ready  input  1  decode accepts ir this cycle
ir_valid  output  1  ir/ir_pc hold a valid instruction
ir  output  32  instruction register
ir_pc  output  32  byte address of the instruction in ir
pc  output  32  current fetch byte address
halted  output  1  high while in HALT state

Behaviour:
- States: FETCH, HALT.
- hold = ir_valid & ~ir_ready. end = (pc[31:2] >= PROG_LEN).
- Reset (rst=1 at rising edge), highest priority, overrides br_taken and any hold:
  - pc <= RESET_PC
  - ir <= 0, ir_pc <= 0, ir_valid <= 0
  - state <= FETCH, halted <= 0
- Priority per rising edge when rst=0: br_taken > hold > normal fetch.
- br_taken=1, any state, even while hold:
  - pc <= {br_target[31:2],2'b00}
  - ir_valid <= 0 (in-flight word squashed; ir/ir_pc may keep stale values)
  - state <= FETCH
  - The squashed instruction never reaches decode even if ir_ready=1 that cycle.
- hold (br_taken=0):
  - pc, ir, ir_pc, ir_valid, state all unchanged.
  - ir must stay bit-stable until accepted.
- FETCH, no hold, end=0:
  - ir <= rom_data, ir_pc <= pc, ir_valid <= 1, pc <= pc + 4.
- FETCH, no hold, end=1:
  - ir_valid <= 0, pc unchanged, state <= HALT, halted <= 1.
  - rom_data is not captured.
- HALT:
  - ir_valid stays 0, pc frozen.
  - Exit only via br_taken (to FETCH at target) or rst.
  - ir_ready is ignored.
- Latency:
  - pc presented after edge N; word captured at edge N+1; ir_valid high after N+1.
  - Full throughput of one instruction per cycle with ir_ready held high.
  - After reset release, the first valid ir (rom[RESET_PC>>2]) appears after the first rising edge with rst=0.
- Width/arithmetic:
  - pc + 4 is modulo 2^32.
  - rom_addr truncates to ADDR_W bits.
  - The end check uses the full pc[31:2], so out-of-range or wrapped addresses halt rather than alias into the ROM.
- A branch to a target with index >= PROG_LEN enters FETCH, then HALT on the next edge with no valid output.
- Simultaneous br_taken and ir_ready with ir_valid=1: the current ir counts as consumed by decode; the next fetch is from the target.
- halted is registered and equals (state==HALT).

Test Plan:
- Reset then ir_ready=1 for 14 cycles:
  - ir sequence 13a0000c, e3a01004, 33a05000, … e1016090 with ir_pc 0x00…0x2C.
  - ir_valid drops after edge 13; halted=1; pc frozen at 0x30.
- Back-pressure: ir_ready=0 for 3 cycles while ir=e3a02002 (ir_pc 0x10):
  - ir, ir_pc, pc=0x14 stable.
  - On release, next word c0533212 follows with no gap or duplicate.
- Branch during stall: ir_valid=1, ir_ready=0, br_taken=1, br_target=0x0000_0006:
  - Next edge ir_valid=0, pc=0x04.
  - Following edge ir=e3a01004, ir_pc=0x04.
- Branch out of HALT: in HALT, br_taken=1, target 0x20:
  - halted=0; then ir=e4901004, ir_pc=0x20.
  - Program runs to 0x2C and halts again.
- Reset mid-run: rst=1 at ir_pc=0x18 while ir_ready=0 and br_taken=1:
  - ir_valid=0, pc=RESET_PC, halted=0.
  - The first edge after release yields ir=13a0000c.
- Out-of-range branch: br_target=0xFFFF_FFFC:
  - FETCH for one edge, then HALT; ir_valid never asserts.
  - rom_addr=6'h3F is driven but never captured.
